// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit driving a word-addressed memory, with byte/half extract
// and read-modify-write for sb/sh.
module lsu_ctrl #(
    parameter int MEM_AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err_align,
    output logic        resp_err_range,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [1:0]  mem_we,
    output logic [2:0]  mem_re,
    input  logic [31:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t      state;
    logic        st;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [15:0] wd;
    logic        acc, ill, mis, oor;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] ld_val, rmw;

    assign req_ready  = rst && state == IDLE;
    assign resp_valid = state == RESP;
    assign mem_we     = {2{state == WRITE}};
    assign mem_re     = 3'b000;
    assign acc        = req_valid && req_ready;
    assign ill = req_store ? req_funct3 > 3'b010 : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign oor = |req_addr[31:MEM_AW+2];

    // Lane selection works on the word captured this cycle from the combinational read port.
    always_comb begin
        half_sel = off[1] ? mem_rd[31:16] : mem_rd[15:0];
        byte_sel = off[0] ? half_sel[15:8] : half_sel[7:0];
        ld_val   = f3[1] ? mem_rd
                 : f3[0] ? {{16{~f3[2] & half_sel[15]}}, half_sel}
                 : {{24{~f3[2] & byte_sel[7]}}, byte_sel};
        rmw      = f3[0] ? (off[1] ? {wd, mem_rd[15:0]} : {mem_rd[31:16], wd})
                 : (mem_rd & ~(32'hFF << {off, 3'b000})) | ({24'b0, wd[7:0]} << {off, 3'b000});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            resp_rdata     <= '0;
            resp_err_align <= 1'b0;
            resp_err_range <= 1'b0;
            mem_a          <= '0;
            mem_wd         <= '0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    st             <= req_store;
                    f3             <= req_funct3;
                    off            <= req_addr[1:0];
                    wd             <= req_wdata[15:0];
                    mem_a          <= {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
                    resp_err_align <= ill || mis;
                    resp_err_range <= oor;
                    if (ill || mis || oor) state <= RESP;
                    else if (req_store && req_funct3 == 3'b010) begin
                        mem_wd <= req_wdata;
                        state  <= WRITE;
                    end else state <= READ;
                end
                READ: if (st) begin
                    mem_wd <= rmw;
                    state  <= WRITE;
                end else begin
                    resp_rdata <= ld_val;
                    state      <= RESP;
                end
                WRITE: state <= RESP;
                RESP: begin
                    resp_err_align <= 1'b0;
                    resp_err_range <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule
